// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, 8N1, LSB first.
// The optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
// tx and busy_o are registered from the current state, so the line follows
// the state machine one cycle later. This gives the one-cycle accept-to-start
// latency, and valid_i/data_i have no combinational path to tx.
module uart_tx #(
    parameter int unsigned CLOCKS_PER_BAUD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx,
    output logic       busy_o
);

    localparam int unsigned BW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_baud_cnt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shreg;
    logic          r_tx;
    logic          r_busy;
    logic          w_baud_last;
    logic          w_ready;
    logic          w_accept;
    logic          w_tx_lvl;

    assign w_baud_last = (r_baud_cnt == BAUD_LAST);
    assign w_ready     = (r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last);
    assign w_accept    = valid_i && w_ready;

    assign ready_o = w_ready;
    assign tx      = r_tx;
    assign busy_o  = r_busy;

    // State, counters and shift register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            if (w_accept) begin
                r_shreg <= data_i;
            end
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_last ? '0 : r_baud_cnt + 1'b1;
        w_bit_nxt   = r_bit_idx;
        unique case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                        w_bit_nxt = '0;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_last) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_last) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = w_accept ? S_START : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Line level implied by the current state.
    always_comb begin
        w_tx_lvl = 1'b1;
        unique case (r_state)
            S_START:    w_tx_lvl = 1'b0;
            S_DATA:     w_tx_lvl = r_shreg[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            S_PARITY:   w_tx_lvl = ^r_shreg;
`endif
            default:    w_tx_lvl = 1'b1;
        endcase
    end

    // Registered line and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_lvl;
            r_busy <= (r_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks tx/busy_o/ready_o every cycle against a line-level model.
// The model keeps a queue of the line levels still owed by accepted frames.
module tb_uart_tx;

    localparam int unsigned CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       tx;
    logic       busy_o;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    logic line_q[$];
    logic e_tx;
    logic e_busy;
    logic m_ready = 1'b0;

    uart_tx #(.CLOCKS_PER_BAUD(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .tx     (tx),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    // Queue the full frame waveform for byte d: start, data LSB first, [parity], stop.
    task automatic push_frame(input logic [7:0] d);
        logic lvl [NBITS];
        lvl[0] = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        lvl[9] = ^d;
`endif
        lvl[NBITS-1] = 1'b1;
        for (int b = 0; b < int'(NBITS); b++)
            for (int c = 0; c < int'(CPB); c++)
                line_q.push_back(lvl[b]);
    endtask

    // Apply inputs for one cycle, advance the model, check all outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic acc;
        valid_i = v;
        data_i  = d;
        rst     = r;
        acc     = !r && v && m_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            line_q.delete();
            e_tx   = 1'b1;
            e_busy = 1'b0;
        end else begin
            if (line_q.size() > 0) begin
                e_tx   = line_q.pop_front();
                e_busy = 1'b1;
            end else begin
                e_tx   = 1'b1;
                e_busy = 1'b0;
            end
            if (acc) push_frame(d);
        end
        m_ready = (line_q.size() <= 1);

        vectors++;
        assert (tx === e_tx) else begin
            miscompares++;
            $error("FAIL tx cyc=%0d observed=%b expected=%b", cyc, tx, e_tx);
        end
        vectors++;
        assert (busy_o === e_busy) else begin
            miscompares++;
            $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy_o, e_busy);
        end
        vectors++;
        assert (ready_o === m_ready) else begin
            miscompares++;
            $error("FAIL ready cyc=%0d observed=%b expected=%b", cyc, ready_o, m_ready);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        int unsigned gap;

        // Reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(3);

        // Directed single frames, including the parity example byte
        step(1'b1, 8'hA5, 1'b0);
        idle(110);
        step(1'b1, 8'h07, 1'b0);
        idle(120);

        // Random bytes with random gaps and stray valid pulses while busy
        for (int k = 0; k < 20; k++) begin
            rb = 8'($urandom);
            step(1'b1, rb, 1'b0);
            gap = $urandom_range(0, 110);
            for (int unsigned g = 0; g < gap; g++)
                step(1'($urandom_range(0, 7) == 0), 8'($urandom), 1'b0);
        end
        idle(120);

        // valid_i held high: back-to-back frames, data changing every cycle
        for (int unsigned i = 0; i < 6 * NBITS * CPB; i++)
            step(1'b1, 8'($urandom), 1'b0);
        idle(120);

        // 8'h3C offered mid-DATA for 5 cycles must be dropped
        step(1'b1, 8'h5A, 1'b0);
        idle(35);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0);
        idle(90);

        // Reset during data bit 3 of 8'hFF, then 8'h00 after a frame of idle
        step(1'b1, 8'hFF, 1'b0);
        idle(44);
        step(1'b0, 8'h00, 1'b1);
        idle(100);
        step(1'b1, 8'h00, 1'b0);
        idle(120);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
